// File: rtl/result_display_queue_if.sv
// Bus bundle between the dual-issue ALU retire stage, the display tick source
// and the result display queue.
interface result_display_queue_if #(
  parameter int DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              push1;
  logic [31:0]       data1;
  logic              push2;
  logic [31:0]       data2;
  logic              tick;
  logic              flush;
  logic [7:0]        disp_value;
  logic              disp_valid;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [7:0]        dropped;

  modport master (
    output push1, data1, push2, data2, tick, flush,
    input  disp_value, disp_valid, count, full, empty, overflow, dropped
  );

  modport slave (
    input  push1, data1, push2, data2, tick, flush,
    output disp_value, disp_valid, count, full, empty, overflow, dropped
  );
endinterface

// File: rtl/result_display_queue.sv
// In-order queue of dual-issue ALU results; each result's low byte is held on
// the 7-segment display for HOLD_TICKS display ticks.
module result_display_queue #(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  result_display_queue_if.slave  bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]         disp_value_q, disp_value_d;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               full_q, empty_q, overflow_q;
  logic [7:0]         dropped_q;
  logic [31:0]        mem [DEPTH];

  logic               pop;
  logic               acc1, acc2, drop1, drop2;
  logic [CNT_W-1:0]   free, n_acc, count_d;
  logic [PTR_W-1:0]   tail2;
  logic [8:0]         drop_sum;
  logic [31:0]        head_data;

  // Acceptance is judged on the registered count; a same-cycle pop frees nothing.
  always_comb begin
    free     = CNT_W'(DEPTH) - count_q;
    acc1     = bus.push1 && (free != '0);
    acc2     = bus.push2 && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !bus.push1));
    drop1    = bus.push1 && !acc1;
    drop2    = bus.push2 && !acc2;
    n_acc    = CNT_W'(acc1) + CNT_W'(acc2);
    tail2    = tail_q + PTR_W'(acc1);
    drop_sum = {1'b0, dropped_q} + 9'(drop1) + 9'(drop2);
    head_data = mem[head_q];
  end

  // Display FSM: next state, hold counter, displayed byte and pop request.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    disp_value_d = disp_value_q;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          disp_value_d = head_data[7:0];
          hold_cnt_d   = '0;
          state_d      = S_SHOW;
        end
      end
      S_SHOW: begin
        if (bus.tick) begin
          if (hold_cnt_q != HOLD_W'(HOLD_TICKS - 1)) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end else if (count_q != '0) begin
            pop          = 1'b1;
            disp_value_d = head_data[7:0];
            hold_cnt_d   = '0;
          end else begin
            state_d      = S_IDLE;
            disp_value_d = '0;
            hold_cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        disp_value_d = '0;
        hold_cnt_d   = '0;
      end
    endcase
    count_d = count_q - CNT_W'(pop) + n_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q   <= '0;
      disp_value_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
    end else if (bus.flush) begin
      hold_cnt_q   <= '0;
      disp_value_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      disp_value_q <= disp_value_d;
      head_q       <= head_q + PTR_W'(pop);
      tail_q       <= tail_q + PTR_W'(n_acc);
      count_q      <= count_d;
      full_q       <= (count_d == CNT_W'(DEPTH));
      empty_q      <= (count_d == '0);
      overflow_q   <= overflow_q | drop1 | drop2;
      dropped_q    <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (acc1 && (PTR_W'(i) == tail_q)) mem[i] <= bus.data1;
        if (acc2 && (PTR_W'(i) == tail2))  mem[i] <= bus.data2;
      end
    end
  end

  assign bus.disp_value = disp_value_q;
  assign bus.disp_valid = (state_q == S_SHOW);
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.overflow   = overflow_q;
  assign bus.dropped    = dropped_q;
endmodule

// File: tb/tb_result_display_queue.sv
// Directed bench for result_display_queue (DEPTH=8, HOLD_TICKS=2).
module tb_result_display_queue;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  result_display_queue_if #(.DEPTH(8)) bus ();

  result_display_queue #(.DEPTH(8), .HOLD_TICKS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.push1 = 1'($urandom);
      bus.push2 = 1'($urandom);
      bus.tick  = 1'($urandom);
      bus.data1 = $urandom;
      bus.data2 = $urandom;
      step();
    end
    n_tests++;
    if (bus.disp_value !== 8'h00 || bus.disp_valid !== 1'b0 || bus.count !== 4'd0 ||
        bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.dropped !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: val=%h vld=%b cnt=%0d full=%b empty=%b ovf=%b drop=%0d, need 00 0 0 0 1 0 0",
               bus.disp_value, bus.disp_valid, bus.count, bus.full, bus.empty, bus.overflow, bus.dropped);
    end
    bus.push1 = 1'b0;
    bus.push2 = 1'b0;
    bus.tick  = 1'b0;
    reset     = 1'b0;
    step();
  endtask

  task automatic test_single_push();
    bus.data1 = 32'h12345678;
    bus.push1 = 1'b1;
    step();
    bus.push1 = 1'b0;
    n_tests++;
    if (bus.count !== 4'd1 || bus.disp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_queued: cnt=%0d vld=%b, need 1 0", bus.count, bus.disp_valid);
    end
    // tick during the load edge must not count toward the hold
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    n_tests++;
    if (bus.disp_valid !== 1'b1 || bus.disp_value !== 8'h78 || bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_shown: vld=%b val=%h cnt=%0d empty=%b, need 1 78 0 1",
               bus.disp_valid, bus.disp_value, bus.count, bus.empty);
    end
    do_tick();
    step();
    n_tests++;
    if (bus.disp_valid !== 1'b1 || bus.disp_value !== 8'h78) begin
      n_fail++;
      $display("FAIL single_hold: vld=%b val=%h, need 1 78", bus.disp_valid, bus.disp_value);
    end
    do_tick();
    n_tests++;
    if (bus.disp_valid !== 1'b0 || bus.disp_value !== 8'h00) begin
      n_fail++;
      $display("FAIL single_release: vld=%b val=%h, need 0 00", bus.disp_valid, bus.disp_value);
    end
  endtask

  task automatic test_ordering();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'hA1; exp_v[1] = 8'hB2; exp_v[2] = 8'hC3;
    bus.data1 = 32'h000000A1; bus.data2 = 32'h000000B2;
    bus.push1 = 1'b1; bus.push2 = 1'b1;
    step();
    bus.data1 = 32'h000000C3; bus.push2 = 1'b0;
    step();
    bus.push1 = 1'b0;
    n_tests++;
    if (bus.disp_value !== 8'hA1 || bus.disp_valid !== 1'b1 || bus.count !== 4'd2) begin
      n_fail++;
      $display("FAIL order_first: val=%h vld=%b cnt=%0d, need a1 1 2", bus.disp_value, bus.disp_valid, bus.count);
    end
    for (int j = 1; j < 3; j++) begin
      do_tick();
      n_tests++;
      if (bus.disp_value !== exp_v[j-1]) begin
        n_fail++;
        $display("FAIL order_hold%0d: val=%h, need %h", j, bus.disp_value, exp_v[j-1]);
      end
      do_tick();
      n_tests++;
      if (bus.disp_value !== exp_v[j] || bus.disp_valid !== 1'b1 || bus.count !== 4'(2 - j)) begin
        n_fail++;
        $display("FAIL order_next%0d: val=%h vld=%b cnt=%0d, need %h 1 %0d",
                 j, bus.disp_value, bus.disp_valid, bus.count, exp_v[j], 2 - j);
      end
    end
    do_tick();
    do_tick();
    step();
    n_tests++;
    if (bus.disp_valid !== 1'b0 || bus.disp_value !== 8'h00 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL order_idle: vld=%b val=%h empty=%b, need 0 00 1", bus.disp_valid, bus.disp_value, bus.empty);
    end
  endtask

  task automatic test_overflow();
    bus.push1 = 1'b1; bus.push2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data1 = {24'hABCDEF, 8'(2 * i)};
      bus.data2 = {24'hABCDEF, 8'(2 * i + 1)};
      step();
    end
    bus.push1 = 1'b0; bus.push2 = 1'b0;
    n_tests++;
    if (bus.disp_value !== 8'h00 || bus.disp_valid !== 1'b1 || bus.count !== 4'd8 || bus.full !== 1'b1 ||
        bus.empty !== 1'b0 || bus.overflow !== 1'b1 || bus.dropped !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_state: val=%h vld=%b cnt=%0d full=%b empty=%b ovf=%b drop=%0d, need 00 1 8 1 0 1 1",
               bus.disp_value, bus.disp_valid, bus.count, bus.full, bus.empty, bus.overflow, bus.dropped);
    end
    // full queue: two drops in one cycle add two
    bus.data1 = 32'hFFFFFFEE; bus.data2 = 32'hFFFFFFDD;
    bus.push1 = 1'b1; bus.push2 = 1'b1;
    step();
    bus.push1 = 1'b0; bus.push2 = 1'b0;
    n_tests++;
    if (bus.dropped !== 8'd3 || bus.count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_double_drop: drop=%0d cnt=%0d, need 3 8", bus.dropped, bus.count);
    end
    for (int j = 1; j <= 8; j++) begin
      do_tick();
      do_tick();
      n_tests++;
      if (bus.disp_value !== 8'(j) || bus.disp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: val=%h vld=%b, need %h 1", j, bus.disp_value, bus.disp_valid, 8'(j));
      end
    end
    n_tests++;
    if (bus.count !== 4'd0 || bus.overflow !== 1'b1 || bus.dropped !== 8'd3) begin
      n_fail++;
      $display("FAIL ovf_sticky: cnt=%0d ovf=%b drop=%0d, need 0 1 3", bus.count, bus.overflow, bus.dropped);
    end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    bus.push1 = 1'b1; bus.push2 = 1'b1;
    bus.data1 = 32'h11; bus.data2 = 32'h22;
    step();
    bus.flush = 1'b0;
    bus.push1 = 1'b0; bus.push2 = 1'b0;
    n_tests++;
    if (bus.disp_valid !== 1'b0 || bus.disp_value !== 8'h00 || bus.count !== 4'd0 ||
        bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.dropped !== 8'd0) begin
      n_fail++;
      $display("FAIL flush_clear: vld=%b val=%h cnt=%0d empty=%b ovf=%b drop=%0d, need 0 00 0 1 0 0",
               bus.disp_valid, bus.disp_value, bus.count, bus.empty, bus.overflow, bus.dropped);
    end
    for (int i = 0; i < 4; i++) begin
      do_tick();
      n_tests++;
      if (bus.disp_valid !== 1'b0 || bus.count !== 4'd0) begin
        n_fail++;
        $display("FAIL flush_no_display%0d: vld=%b cnt=%0d, need 0 0", i, bus.disp_valid, bus.count);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.data1 = 32'h5A; bus.data2 = 32'h6B;
    bus.push1 = 1'b1; bus.push2 = 1'b1;
    step();
    bus.push1 = 1'b0; bus.push2 = 1'b0;
    step();
    n_tests++;
    if (bus.disp_value !== 8'h5A || bus.disp_valid !== 1'b1 || bus.count !== 4'd1) begin
      n_fail++;
      $display("FAIL arst_setup: val=%h vld=%b cnt=%0d, need 5a 1 1", bus.disp_value, bus.disp_valid, bus.count);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.disp_valid !== 1'b0 || bus.disp_value !== 8'h00 || bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_immediate: vld=%b val=%h cnt=%0d empty=%b, need 0 00 0 1",
               bus.disp_valid, bus.disp_value, bus.count, bus.empty);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (bus.disp_valid !== 1'b0 || bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_release: vld=%b cnt=%0d empty=%b, need 0 0 1", bus.disp_valid, bus.count, bus.empty);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.push1 = 1'b0;
    bus.push2 = 1'b0;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.tick  = 1'b0;
    bus.flush = 1'b0;
    test_reset();
    test_single_push();
    test_ordering();
    test_overflow();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/result_display_queue.md
# result_display_queue

Buffers ALU results from both datapaths and presents them, one at a time, to the two-digit 7-segment multiplexer. It sits directly downstream of the dual-issue ALUs. Each retired result is queued in order, datapath 1 before datapath 2. The queue then shows the result's low byte for a fixed number of slow-clock ticks, so no result is lost between display samples.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2
- HOLD_TICKS, 2, tick pulses each value stays on the display; ≥1

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- push1  in  1  datapath-1 result valid this cycle
- data1  in  32  datapath-1 ALU result
- push2  in  1  datapath-2 result valid this cycle
- data2  in  32  datapath-2 ALU result
- tick  in  1  single-cycle display-advance strobe (divided clock edge)
- flush  in  1  synchronous clear of queue, display and status
- disp_value  out  8  low byte of the result currently displayed; 0 when not displaying
- disp_valid  out  1  high while in SHOW
- count  out  $clog2(DEPTH)+1  entries waiting in FIFO (excludes displayed value)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky; set when any push is dropped
- dropped  out  8  saturating count of dropped pushes (stops at 255)

## Operation
- Storage: circular FIFO of DEPTH×32 bits. Head and tail pointers wrap modulo DEPTH.
- Push ordering: when both pushes are asserted, data1 is enqueued before data2.
- Acceptance uses the registered count at the start of the cycle. A same-cycle pop creates no room, and there is no bypass.
  - free = DEPTH − count.
  - free ≥ 2: both pushes are accepted.
  - free = 1 with both pushes: data1 is accepted and data2 is dropped.
  - free = 0: all pushes are dropped.
- Each dropped push sets overflow and increments dropped (saturating). Two drops in one cycle add 2.
- FSM states: IDLE, SHOW.
- IDLE:
  - disp_valid=0, disp_value=0.
  - If count>0: pop the head, disp_value←head[7:0], hold_cnt←0, go to SHOW.
  - tick is ignored.
- SHOW:
  - On tick with hold_cnt<HOLD_TICKS−1: hold_cnt++.
  - On tick with hold_cnt==HOLD_TICKS−1:
    - count>0: pop the next head, load disp_value, hold_cnt←0, stay in SHOW.
    - count==0: go to IDLE, disp_value←0.
- count_next = count − pop + accepted pushes. Pop and push may occur in the same cycle.
- flush has priority over everything in its cycle.
  - FIFO is emptied; pointers, count, overflow, dropped and hold_cnt are zeroed.
  - State goes to IDLE.
  - Same-cycle pushes are discarded and are not counted as dropped.
- reset yields the same state as flush, applied asynchronously.

## Timing
- Reset values: disp_value=0, disp_valid=0, count=0, full=0, empty=1, overflow=0, dropped=0, state IDLE.
- Outputs change immediately on reset assertion, without waiting for a clock edge.
- Latency to display: a push sampled at edge k into an empty queue in IDLE is displayed after edge k+1. disp_valid is high two cycles after push is first asserted.
- Display duration: each value stays for exactly HOLD_TICKS ticks. The change occurs at the edge sampling the final tick.
- A tick in the same cycle a value is loaded from IDLE is not counted.
- Back-to-back: in SHOW with count>0, the next value replaces the current one at the final-tick edge, with no gap cycle.
- All status outputs are registered or derived from registered count. None of them combinationally depend on push or tick.
- Reset deasserted mid-operation restarts from the IDLE/empty state. No partial entry survives.

## Test plan
- Reset: assert reset for 3 cycles with random push/tick inputs. Expect all outputs at reset values, empty=1.
- Single push (HOLD_TICKS=2): push1 with data1=0x12345678 for one cycle at cycle 0.
  - disp_valid=1 and disp_value=0x78 from cycle 2.
  - After 2 ticks: disp_valid=0 and disp_value=0 next cycle.
- Ordering: push1=0xA1 and push2=0xB2 in the same cycle, then push1=0xC3 the next cycle.
  - Display shows 0xA1, 0xB2, 0xC3 in order, each for 2 ticks, with no gaps.
  - Ends in IDLE.
- Overflow (DEPTH=8, tick held low): push1 and push2 both asserted for 5 consecutive cycles (10 values).
  - 0 is displayed; count=8, full=1.
  - overflow=1, dropped=1; the dropped value is the 10th.
- Flush mid-SHOW with push1 and push2 asserted in the same cycle.
  - Next cycle: disp_valid=0, count=0, overflow=0, dropped=0.
  - Subsequent ticks cause no display.
- Async reset mid-SHOW: raise reset between clock edges. disp_valid and disp_value go to 0 before the next edge; FIFO is empty after release.
